id_hazard_unit: RTL and testbench
=================================

# id_hazard_unit

Parametrised operand-forwarding and interlock unit for the decode stage of the pipelined MIPS core. It sits between the register file and the ID/EX pipeline register, and generalises ID-stage forwarding from a fixed EX/MEM/WB triple to `FWD_STAGES` producer stages. It adds three behaviours: a load-use interlock, a multi-cycle MULT/DIV busy tracker that stalls HI/LO consumers, and a saturating stall-cycle counter.

## Interface
- `FWD_STAGES`, 3, number of forwarding sources; index 0 is the youngest stage (EX).
- `DATA_W`, 32, operand width.
- `MUL_LAT`, 4, MULT/MULTU busy cycles (≥1).
- `DIV_LAT`, 32, DIV/DIVU busy cycles (≥1, ≥ `MUL_LAT`).
- `CNT_W`, 16, stall-counter width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_valid` in 1: the ID instruction is valid.
- `id_flush` in 1: kill the ID instruction this cycle.
- `id_re1`, `id_re2` in 1 each: the operand is actually read.
- `id_ra1`, `id_ra2` in 5 each: `reg_enum` source addresses (rs, rt).
- `rf_rd1`, `rf_rd2` in `DATA_W` each: register-file read data.
- `fwd_rfwe` in `FWD_STAGES`: producer write enable, per stage.
- `fwd_rfwa` in `5*FWD_STAGES`: producer destination; stage i occupies bits `[5i+4:5i]`.
- `fwd_rfwd` in `DATA_W*FWD_STAGES`: producer data.
- `fwd_pend` in `FWD_STAGES`: producer data not yet valid (load before MEM completes).
- `id_hilo_rd` in 1: the ID instruction is MFHI or MFLO.
- `id_muldiv` in 1: the ID instruction is MULT, MULTU, DIV or DIVU.
- `id_is_div` in 1: qualifies `id_muldiv`; 1 selects DIV latency.
- `id_src1`, `id_src2` out `DATA_W` each: forwarded operands.
- `id_stall` out 1: hold PC and IF/ID, insert a bubble into ID/EX.
- `id_fire` out 1: the ID instruction advances this cycle.
- `hilo_busy` out 1: a MULT/DIV is in flight.
- `hilo_done` out 1: one-cycle pulse on the last busy cycle.
- `stall_cnt` out `CNT_W`: count of stall cycles.

## Operation
- **Operand match.** Operand k matches stage i when all of the following hold: `id_rek`, `fwd_rfwe[i]`, `fwd_rfwa[i]==id_rak`, and `id_rak != R0`.
- **Forwarding.** The lowest matching i wins. Its `fwd_rfwd` drives `id_srck`. With no match, `id_srck = rf_rdk`. `id_srck = 0` whenever `id_rak == R0`.
- **Load-use.** If the winning stage for either operand has `fwd_pend=1`, raise `lu_stall`. A pending match in an older stage that is shadowed by a younger non-pending match does not stall.
- **HI/LO interlock.** Raise `hl_stall` when `hilo_busy` is set and either `id_hilo_rd` or `id_muldiv` is set.
- **Stall and fire.**
  - `id_stall = id_valid & ~id_flush & (lu_stall | hl_stall)`.
  - `id_fire = id_valid & ~id_flush & ~id_stall`.
- **Muldiv FSM**, states IDLE and BUSY, with a down-counter `cnt` of width `$clog2(DIV_LAT+1)`:
  - IDLE→BUSY on `id_fire & id_muldiv`; load `cnt = id_is_div ? DIV_LAT-1 : MUL_LAT-1`.
  - In BUSY, decrement every cycle.
  - BUSY→IDLE when `cnt==0`; `hilo_done` is asserted in that same cycle.
  - `hilo_busy = (state==BUSY)`.
- **Flush.** `id_flush` only suppresses the ID instruction. It never cancels a muldiv already in BUSY.
- **Stall counter.** `stall_cnt` increments when `id_stall` is set and saturates at all-ones (no wrap).
- **Reset values.** State IDLE, `cnt=0`, `stall_cnt=0`. This gives `hilo_busy=0` and `hilo_done=0`. Combinational outputs follow their inputs during reset.
- **Reset mid-BUSY.** Return to IDLE immediately. No `hilo_done` is produced.

## Timing
- `id_src*`, `id_stall` and `id_fire` are combinational, with zero latency from the inputs in the same cycle.
- `hilo_busy` rises the cycle after the accepting `id_fire`.
- Busy duration:
  - It stays high for exactly `MUL_LAT` or `DIV_LAT` cycles.
  - A consumer issued in the cycle after `hilo_done` fires without stalling.
  - Back-to-back MULTs are therefore spaced `MUL_LAT+1` cycles apart.
- `stall_cnt` updates on the clock edge after the stall cycle.
- Simultaneous events:
  - `id_flush` together with a would-be stall: no stall and no count.
  - `id_muldiv` in the `hilo_done` cycle stalls. BUSY is still set in that cycle, so acceptance happens the following cycle.

## Structure
- Add to `mips_cpu_pkg`: `localparam FWD_EX=0`, `FWD_MEM=1`, `FWD_WB=2`, and `typedef enum logic {HL_IDLE, HL_BUSY} hilo_state_enum`.
- Reuse the existing `reg_enum` and `word_t`.
- One sub-module, `fwd_select`: a per-operand priority mux producing data and a `pend` flag. It is instantiated twice.

## Test plan
- **No hazard.**
  - Stimulus: `id_ra1=5`, `rf_rd1=0x11`, all `fwd_rfwe=0`.
  - Response: `id_src1=0x11`, `id_fire=1`, `id_stall=0`.
- **Priority.**
  - Stimulus: stages 0, 1 and 2 all write r8 with data `0xA`, `0xB`, `0xC`; `id_ra2=8`.
  - Response: `id_src2=0xA`.
  - Follow-up: deassert stage 0. Response: `0xB`.
- **R0 and load-use.**
  - Stimulus: `id_ra1=0` with stage 0 writing r0, data `0xFF`.
  - Response: `id_src1=0`, no stall.
  - Stimulus: stage 0 writes r3 with `fwd_pend=1`; `id_ra1=3`.
  - Response: `id_stall=1`, `stall_cnt` 0→1.
- **DIV busy.**
  - Stimulus: fire DIV (`DIV_LAT=32`), then hold MFLO in ID.
  - Response: stall for 32 cycles, `hilo_done` in the 32nd busy cycle, MFLO fires on the next cycle.
- **Flush and reset.**
  - Stimulus: assert `id_flush` during a load-use match.
  - Response: `id_stall=0`, `id_fire=0`.
  - Stimulus: assert `rst_n=0` while in BUSY.
  - Response: `hilo_busy=0` asynchronously, `stall_cnt=0`.
- **Saturation.**
  - Stimulus: `CNT_W=4`, 20 stall cycles.
  - Response: `stall_cnt=15`.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared MIPS core types: architectural register names, datapath word, and
// ID-stage hazard-unit constants.
package mips_cpu_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [4:0] {
    R0,  R1,  R2,  R3,  R4,  R5,  R6,  R7,
    R8,  R9,  R10, R11, R12, R13, R14, R15,
    R16, R17, R18, R19, R20, R21, R22, R23,
    R24, R25, R26, R27, R28, R29, R30, R31
  } reg_enum;

  // Forwarding source indices, youngest first
  localparam int unsigned FWD_EX  = 0;
  localparam int unsigned FWD_MEM = 1;
  localparam int unsigned FWD_WB  = 2;

  typedef enum logic {HL_IDLE, HL_BUSY} hilo_state_enum;

endpackage

// File: rtl/id_hazard_unit_fwd_select.sv
// Per-operand forwarding priority mux: youngest matching producer wins and
// reports whether its data is still pending.
module fwd_select
  import mips_cpu_pkg::*;
#(
  parameter int unsigned FWD_STAGES = 3,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                         i_re,
  input  reg_enum                      i_ra,
  input  logic [DATA_W-1:0]            i_rf_rd,
  input  logic [FWD_STAGES-1:0]        i_rfwe,
  input  logic [5*FWD_STAGES-1:0]      i_rfwa,
  input  logic [DATA_W*FWD_STAGES-1:0] i_rfwd,
  input  logic [FWD_STAGES-1:0]        i_pend,
  output logic [DATA_W-1:0]            o_data,
  output logic                         o_pend
);

  always_comb begin
    o_data = i_rf_rd;
    o_pend = 1'b0;
    // Walk oldest to youngest so the youngest match overwrites the rest
    for (int i = int'(FWD_STAGES) - 1; i >= 0; i--) begin
      if (i_re && i_rfwe[i] && (i_rfwa[5*i +: 5] == i_ra) && (i_ra != R0)) begin
        o_data = i_rfwd[DATA_W*i +: DATA_W];
        o_pend = i_pend[i];
      end
    end
    if (i_ra == R0) begin
      o_data = '0;
      o_pend = 1'b0;
    end
  end

endmodule

// File: rtl/id_hazard_unit.sv
// Decode-stage operand forwarding with load-use and HI/LO interlocks, a
// MULT/DIV busy tracker and a saturating stall-cycle counter.
module id_hazard_unit
  import mips_cpu_pkg::*;
#(
  parameter int unsigned FWD_STAGES = 3,
  parameter int unsigned DATA_W     = $bits(word_t),
  parameter int unsigned MUL_LAT    = 4,
  parameter int unsigned DIV_LAT    = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         id_valid,
  input  logic                         id_flush,
  input  logic                         id_re1,
  input  logic                         id_re2,
  input  reg_enum                      id_ra1,
  input  reg_enum                      id_ra2,
  input  logic [DATA_W-1:0]            rf_rd1,
  input  logic [DATA_W-1:0]            rf_rd2,
  input  logic [FWD_STAGES-1:0]        fwd_rfwe,
  input  logic [5*FWD_STAGES-1:0]      fwd_rfwa,
  input  logic [DATA_W*FWD_STAGES-1:0] fwd_rfwd,
  input  logic [FWD_STAGES-1:0]        fwd_pend,
  input  logic                         id_hilo_rd,
  input  logic                         id_muldiv,
  input  logic                         id_is_div,
  output logic [DATA_W-1:0]            id_src1,
  output logic [DATA_W-1:0]            id_src2,
  output logic                         id_stall,
  output logic                         id_fire,
  output logic                         hilo_busy,
  output logic                         hilo_done,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int unsigned LAT_W = $clog2(DIV_LAT + 1);
  localparam logic [LAT_W-1:0] MUL_LOAD = LAT_W'(MUL_LAT - 1);
  localparam logic [LAT_W-1:0] DIV_LOAD = LAT_W'(DIV_LAT - 1);

  logic           w_pend1;
  logic           w_pend2;
  logic           w_lu_stall;
  logic           w_hl_stall;
  hilo_state_enum r_state;
  hilo_state_enum w_state_nxt;
  logic [LAT_W-1:0] r_cnt;
  logic [LAT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  fwd_select #(
    .FWD_STAGES(FWD_STAGES),
    .DATA_W    (DATA_W)
  ) u_fwd1 (
    .i_re   (id_re1),
    .i_ra   (id_ra1),
    .i_rf_rd(rf_rd1),
    .i_rfwe (fwd_rfwe),
    .i_rfwa (fwd_rfwa),
    .i_rfwd (fwd_rfwd),
    .i_pend (fwd_pend),
    .o_data (id_src1),
    .o_pend (w_pend1)
  );

  fwd_select #(
    .FWD_STAGES(FWD_STAGES),
    .DATA_W    (DATA_W)
  ) u_fwd2 (
    .i_re   (id_re2),
    .i_ra   (id_ra2),
    .i_rf_rd(rf_rd2),
    .i_rfwe (fwd_rfwe),
    .i_rfwa (fwd_rfwa),
    .i_rfwd (fwd_rfwd),
    .i_pend (fwd_pend),
    .o_data (id_src2),
    .o_pend (w_pend2)
  );

  assign w_lu_stall = w_pend1 | w_pend2;
  assign hilo_busy  = (r_state == HL_BUSY);
  assign w_hl_stall = hilo_busy & (id_hilo_rd | id_muldiv);
  assign id_stall   = id_valid & ~id_flush & (w_lu_stall | w_hl_stall);
  assign id_fire    = id_valid & ~id_flush & ~id_stall;
  assign stall_cnt  = r_stall_cnt;

  // cnt counts remaining busy cycles minus one; done fires when it reaches zero
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    hilo_done   = 1'b0;
    unique case (r_state)
      HL_IDLE: begin
        if (id_fire && id_muldiv) begin
          w_state_nxt = HL_BUSY;
          w_cnt_nxt   = id_is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      HL_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = HL_IDLE;
          hilo_done   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HL_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (id_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_hazard_unit.sv
// Scoreboard bench for id_hazard_unit: a behavioural model queues expected
// outputs per cycle and a negedge monitor compares them against the DUT.
module tb_id_hazard_unit;
  import mips_cpu_pkg::*;

  localparam int unsigned NS      = 3;
  localparam int unsigned DW      = 32;
  localparam int unsigned MULL    = 4;
  localparam int unsigned DIVL    = 32;
  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_flush, id_re1, id_re2;
  reg_enum id_ra1, id_ra2;
  logic [DW-1:0] rf_rd1, rf_rd2;
  logic [NS-1:0] fwd_rfwe, fwd_pend;
  logic [5*NS-1:0] fwd_rfwa;
  logic [DW*NS-1:0] fwd_rfwd;
  logic id_hilo_rd, id_muldiv, id_is_div;
  logic [DW-1:0] id_src1, id_src2;
  logic id_stall, id_fire, hilo_busy, hilo_done;
  logic [CW-1:0] stall_cnt;

  id_hazard_unit #(
    .FWD_STAGES(NS),
    .DATA_W    (DW),
    .MUL_LAT   (MULL),
    .DIV_LAT   (DIVL),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_valid  (id_valid),
    .id_flush  (id_flush),
    .id_re1    (id_re1),
    .id_re2    (id_re2),
    .id_ra1    (id_ra1),
    .id_ra2    (id_ra2),
    .rf_rd1    (rf_rd1),
    .rf_rd2    (rf_rd2),
    .fwd_rfwe  (fwd_rfwe),
    .fwd_rfwa  (fwd_rfwa),
    .fwd_rfwd  (fwd_rfwd),
    .fwd_pend  (fwd_pend),
    .id_hilo_rd(id_hilo_rd),
    .id_muldiv (id_muldiv),
    .id_is_div (id_is_div),
    .id_src1   (id_src1),
    .id_src2   (id_src2),
    .id_stall  (id_stall),
    .id_fire   (id_fire),
    .hilo_busy (hilo_busy),
    .hilo_done (hilo_done),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] src1;
    logic [DW-1:0] src2;
    logic          stall;
    logic          fire;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_busy_left = 0;  // busy cycles still to come
  int   m_cnt       = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void fwd_model(input logic re, input logic [4:0] ra,
                                    input logic [DW-1:0] rd,
                                    output logic [DW-1:0] d, output logic p);
    d = rd;
    p = 1'b0;
    if (ra == 5'd0) begin
      d = '0;
      return;
    end
    if (!re) return;
    for (int s = 0; s < int'(NS); s++) begin
      if (fwd_rfwe[s] && fwd_rfwa[5*s +: 5] == ra) begin
        d = fwd_rfwd[DW*s +: DW];
        p = fwd_pend[s];
        return;
      end
    end
  endfunction

  // Expected outputs for the current inputs, then advance the model one clock
  task automatic issue();
    exp_t e;
    logic p1, p2, lu, hl;
    fwd_model(id_re1, id_ra1, rf_rd1, e.src1, p1);
    fwd_model(id_re2, id_ra2, rf_rd2, e.src2, p2);
    lu      = p1 | p2;
    e.busy  = (m_busy_left > 0);
    e.done  = (m_busy_left == 1);
    hl      = e.busy && (id_hilo_rd || id_muldiv);
    e.stall = id_valid && !id_flush && (lu || hl);
    e.fire  = id_valid && !id_flush && !e.stall;
    e.cnt   = CW'(m_cnt);
    exp_q.push_back(e);
    if (m_busy_left > 0) m_busy_left--;
    else if (e.fire && id_muldiv) m_busy_left = id_is_div ? int'(DIVL) : int'(MULL);
    if (e.stall && m_cnt < CNT_MAX) m_cnt++;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("src1", id_src1, mon_e.src1);
      chk("src2", id_src2, mon_e.src2);
      chk("stall", id_stall, mon_e.stall);
      chk("fire", id_fire, mon_e.fire);
      chk("busy", hilo_busy, mon_e.busy);
      chk("done", hilo_done, mon_e.done);
      chk("stall_cnt", stall_cnt, mon_e.cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_flush = 0; id_re1 = 0; id_re2 = 0;
    id_ra1 = R0; id_ra2 = R0; rf_rd1 = '0; rf_rd2 = '0;
    fwd_rfwe = '0; fwd_rfwa = '0; fwd_rfwd = '0; fwd_pend = '0;
    id_hilo_rd = 0; id_muldiv = 0; id_is_div = 0;
  endtask

  task automatic set_stage(input int s, input logic we, input logic [4:0] wa,
                           input logic [DW-1:0] wd, input logic pend);
    fwd_rfwe[s]          = we;
    fwd_rfwa[5*s +: 5]   = wa;
    fwd_rfwd[DW*s +: DW] = wd;
    fwd_pend[s]          = pend;
  endtask

  task automatic rand_inputs();
    id_valid   = ($urandom_range(0, 9) != 0);
    id_flush   = ($urandom_range(0, 9) == 0);
    id_re1     = 1'($urandom);
    id_re2     = 1'($urandom);
    id_ra1     = reg_enum'(5'($urandom_range(0, 7)));
    id_ra2     = reg_enum'(5'($urandom_range(0, 7)));
    rf_rd1     = $urandom;
    rf_rd2     = $urandom;
    for (int s = 0; s < int'(NS); s++)
      set_stage(s, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 4) == 0));
    id_hilo_rd = ($urandom_range(0, 5) == 0);
    id_muldiv  = ($urandom_range(0, 7) == 0);
    id_is_div  = ($urandom_range(0, 3) == 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("rst_busy", hilo_busy, 0);
    chk("rst_done", hilo_done, 0);
    chk("rst_cnt", stall_cnt, 0);
    m_busy_left = 0;
    m_cnt       = 0;
    #2;
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    int done_at;
    int fired;
    clear_inputs();
    rst_n = 0;
    #3;
    chk("reset_busy", hilo_busy, 0);
    chk("reset_done", hilo_done, 0);
    chk("reset_cnt", stall_cnt, 0);
    #9;
    rst_n = 1;

    // No hazard
    step(); clear_inputs();
    id_valid = 1; id_re1 = 1; id_ra1 = R5; rf_rd1 = 32'h11;
    issue(); #2;
    chk("nohaz_src1", id_src1, 32'h11);
    chk("nohaz_fire", id_fire, 1);
    chk("nohaz_stall", id_stall, 0);

    // Priority across stages, then with stage 0 removed
    step(); clear_inputs();
    id_valid = 1; id_re2 = 1; id_ra2 = R8; rf_rd2 = 32'h99;
    set_stage(0, 1, 5'd8, 32'hA, 0);
    set_stage(1, 1, 5'd8, 32'hB, 0);
    set_stage(2, 1, 5'd8, 32'hC, 0);
    issue(); #2;
    chk("prio_ex", id_src2, 32'hA);
    step(); fwd_rfwe[0] = 0;
    issue(); #2;
    chk("prio_mem", id_src2, 32'hB);

    // Shadowed pending load in MEM does not stall
    step(); fwd_rfwe[0] = 1; fwd_pend[1] = 1;
    issue(); #2;
    chk("shadow_stall", id_stall, 0);

    // R0 reads zero regardless of producers
    step(); clear_inputs();
    id_valid = 1; id_re1 = 1; id_ra1 = R0; rf_rd1 = 32'h55;
    set_stage(0, 1, 5'd0, 32'hFF, 1);
    issue(); #2;
    chk("r0_src1", id_src1, 0);
    chk("r0_stall", id_stall, 0);

    // Load-use stall and counter step
    step(); clear_inputs();
    id_valid = 1; id_re1 = 1; id_ra1 = R3;
    set_stage(0, 1, 5'd3, 32'h33, 1);
    issue(); #2;
    chk("lu_stall", id_stall, 1);
    chk("lu_cnt0", stall_cnt, 0);
    // Flush overrides the stall; counter shows the previous stall
    step(); id_flush = 1;
    issue(); #2;
    chk("lu_cnt1", stall_cnt, 1);
    chk("flush_stall", id_stall, 0);
    chk("flush_fire", id_fire, 0);

    // DIV then MFLO held in ID
    step(); clear_inputs();
    id_valid = 1; id_muldiv = 1; id_is_div = 1;
    issue(); #2;
    chk("div_fire", id_fire, 1);
    stalls = 0; done_at = -1; fired = 0;
    for (int c = 0; c < 40 && !fired; c++) begin
      step(); clear_inputs();
      id_valid = 1; id_hilo_rd = 1;
      issue(); #2;
      if (hilo_done) done_at = c;
      if (id_stall) stalls++;
      if (id_fire) fired = 1;
    end
    chk("div_stalls", stalls, 32);
    chk("div_done_cycle", done_at, 31);
    chk("mflo_fired", fired, 1);

    // MULT held continuously: accepted every MUL_LAT+1 cycles
    for (int c = 0; c < 16; c++) begin
      step(); clear_inputs();
      id_valid = 1; id_muldiv = 1;
      issue();
    end

    for (int c = 0; c < 400; c++) begin
      step(); rand_inputs();
      issue();
    end

    // Reset in the middle of a DIV
    step(); clear_inputs();
    id_valid = 1; id_muldiv = 1; id_is_div = 1;
    issue();
    for (int c = 0; c < 5; c++) begin
      step(); clear_inputs();
      issue();
    end
    do_reset();

    // Saturation: 20 load-use stall cycles
    for (int c = 0; c < 20; c++) begin
      step(); clear_inputs();
      id_valid = 1; id_re2 = 1; id_ra2 = R3;
      set_stage(0, 1, 5'd3, 32'h1, 1);
      issue();
    end
    step(); clear_inputs();
    issue(); #2;
    chk("sat_cnt", stall_cnt, 15);

    for (int c = 0; c < 100; c++) begin
      step(); rand_inputs();
      issue();
    end

    step(); clear_inputs();
    @(negedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
